// File: rtl/bootram_uart_loader_pkg.sv
// Shared definitions for the boot RAM UART loader: FSM state encoding,
// default framing bytes and timeout counter width.
// Frame field order on the wire: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA[LEN], CSUM.
package bootram_uart_loader_pkg;

  // Frame-walking FSM; states follow the on-wire field order.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_CSUM,
    S_RESP
  } state_e;

  localparam logic [7:0] SYNC_DEF = 8'hA5;
  localparam logic [7:0] ACK_DEF  = 8'h06;
  localparam logic [7:0] NAK_DEF  = 8'h15;

  localparam int TMO_W = 24;

endpackage

// File: rtl/bootram_uart_loader_timeout.sv
// loader_timeout: inter-byte watchdog for the frame receiver.
// Ports:
//   clk, resetn  clock / async active-low reset
//   en           count while high; counter is held at 0 while low
//   clr          restart the count (a byte arrived)
//   expire       one-cycle pulse when LIMIT idle cycles have elapsed
// A clear in the expiry cycle suppresses the pulse, so a byte arriving
// right at the deadline is still accepted.
module loader_timeout
  import bootram_uart_loader_pkg::*;
#(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] cnt;

  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         cnt <= '0;
    else if (clr || !en) cnt <= '0;
    else                 cnt <= cnt + TMO_W'(1);
  end

endmodule

// File: rtl/bootram_uart_loader.sv
// bootram_uart_loader: receives a framed boot image on the UART RX byte
// stream, writes it into the boot RAM write port and answers ACK/NAK on TX.
// The CPU is held in reset from SYNC until the response has been accepted.
// Ports:
//   clk, resetn          clock / async active-low reset
//   rx_data, rx_valid    received byte + one-cycle strobe
//   tx_data, tx_valid    response byte, held until tx_ready
//   tx_ready             TX side accepts the response
//   ram_ce, ram_wre      one-cycle write strobe per data byte
//   ram_ad, ram_din      write address / data
//   cpu_hold             1 = keep CPU in reset
//   done                 pulse on ACK handshake
//   err                  sticky NAK flag, cleared at next SYNC
module bootram_uart_loader
  import bootram_uart_loader_pkg::*;
#(
  parameter int         ADDR_W      = 11,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEF,
  parameter logic [7:0] ACK_BYTE    = ACK_DEF,
  parameter logic [7:0] NAK_BYTE    = NAK_DEF,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_e            state, state_nx;
  logic [7:0]        addr_h, len_h, sum;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       remaining;
  logic              resp_ack;
  logic              wr_q;
  logic [ADDR_W-1:0] wr_ad;
  logic [7:0]        wr_din;

  logic [15:0]       len_nx;
  logic [7:0]        sum_nx;
  logic              len_bad;
  logic              tmo_en, tmo_expire;
  logic              resp_load, resp_ack_nx, hs, done_c;

  assign len_nx  = {len_h, rx_data};
  assign sum_nx  = sum + rx_data;
  assign len_bad = (len_nx == 16'd0) || ({1'b0, len_nx} > DEPTH);
  assign tmo_en  = (state != S_IDLE) && (state != S_RESP);

  loader_timeout #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .resetn (resetn),
    .en     (tmo_en),
    .clr    (rx_valid),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    resp_load   = 1'b0;
    resp_ack_nx = 1'b0;
    hs          = 1'b0;
    done_c      = 1'b0;
    case (state)
      S_IDLE:   if (rx_valid && rx_data == SYNC_BYTE) state_nx = S_ADDR_H;
      S_ADDR_H: if (rx_valid) state_nx = S_ADDR_L;
      S_ADDR_L: if (rx_valid) state_nx = S_LEN_H;
      S_LEN_H:  if (rx_valid) state_nx = S_LEN_L;
      S_LEN_L: begin
        if (rx_valid) begin
          if (len_bad) begin
            state_nx  = S_RESP;
            resp_load = 1'b1;
          end else begin
            state_nx  = S_DATA;
          end
        end
      end
      S_DATA:   if (rx_valid && remaining == 16'd1) state_nx = S_CSUM;
      S_CSUM: begin
        if (rx_valid) begin
          state_nx    = S_RESP;
          resp_load   = 1'b1;
          resp_ack_nx = (sum_nx == 8'd0);
        end
      end
      S_RESP: begin
        // rx bytes are dropped here; only the TX handshake moves us on
        if (tx_ready) begin
          state_nx = S_IDLE;
          hs       = 1'b1;
          done_c   = resp_ack;
        end
      end
      default:  state_nx = S_IDLE;
    endcase
    // expiry can only fire without rx_valid, so it never races a byte
    if (tmo_expire) begin
      state_nx    = S_RESP;
      resp_load   = 1'b1;
      resp_ack_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_h    <= '0;
      len_h     <= '0;
      sum       <= '0;
      addr      <= '0;
      remaining <= '0;
      resp_ack  <= 1'b0;
      wr_q      <= 1'b0;
      wr_ad     <= '0;
      wr_din    <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      cpu_hold  <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (resp_load) begin
        tx_valid <= 1'b1;
        tx_data  <= resp_ack_nx ? ACK_BYTE : NAK_BYTE;
        resp_ack <= resp_ack_nx;
      end
      if (hs) begin
        tx_valid <= 1'b0;
        cpu_hold <= 1'b0;
        if (!resp_ack) err <= 1'b1;
      end
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              cpu_hold <= 1'b1;
              err      <= 1'b0;
              sum      <= '0;
            end
          end
          S_ADDR_H: addr_h    <= rx_data;
          S_ADDR_L: addr      <= ADDR_W'({addr_h, rx_data});
          S_LEN_H:  len_h     <= rx_data;
          S_LEN_L:  remaining <= len_nx;
          S_DATA: begin
            // registered write: strobe appears the cycle after the byte
            wr_q      <= 1'b1;
            wr_ad     <= addr;
            wr_din    <= rx_data;
            addr      <= addr + ADDR_W'(1);
            sum       <= sum_nx;
            remaining <= remaining - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // RAM port is only driven while this block owns it (CPU held)
  assign ram_ce  = wr_q & cpu_hold;
  assign ram_wre = wr_q & cpu_hold;
  assign ram_ad  = cpu_hold ? wr_ad  : '0;
  assign ram_din = cpu_hold ? wr_din : '0;
  assign done    = done_c;

endmodule

// File: tb/tb_bootram_uart_loader.sv
// Directed bench for bootram_uart_loader: table of whole frames with
// hand-computed writes/responses, plus timeout, TX stall and reset cases.
module tb_bootram_uart_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ram_ce, ram_wre;
  logic [10:0] ram_ad;
  logic [7:0]  ram_din;
  logic        cpu_hold, done, err;

  always #5 clk = ~clk;

  bootram_uart_loader #(.TIMEOUT_CYC(100)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ram_ce   (ram_ce),
    .ram_wre  (ram_wre),
    .ram_ad   (ram_ad),
    .ram_din  (ram_din),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic [0:11][7:0] b;
    int               n;
    int               gap;
    logic [7:0]       tx;
    int               nwr;
    logic [0:4][10:0] wa;
    logic [0:4][7:0]  wd;
    logic             err;
  } vec_t;

  vec_t v[8];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done;
  logic [10:0] wq_a[$];
  logic [7:0]  wq_d[$];
  logic        wq_w[$];
  int          wq_c[$];
  logic [7:0]  rsp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_ce) begin
      wq_a.push_back(ram_ad);
      wq_d.push_back(ram_din);
      wq_w.push_back(ram_wre);
      wq_c.push_back(cyc);
    end
    if (tx_valid && tx_ready) rsp_q.push_back(tx_data);
    if (done) n_done++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    wq_a.delete(); wq_d.delete(); wq_w.delete(); wq_c.delete();
    rsp_q.delete();
    n_done = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_resp(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      if (rsp_q.size() > 0) break;
      @(posedge clk); #1;
    end
    if (k == 300) chk({name, "_resp_timeout"}, 0, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    clr_mon();
    for (int j = 0; j < v[i].n; j++) send(v[i].b[j], v[i].gap);
    wait_resp(nm);
    chk({nm, "_nresp"}, rsp_q.size(), 1);
    if (rsp_q.size() > 0) chk({nm, "_tx"}, rsp_q[0], v[i].tx);
    chk({nm, "_nwr"}, wq_a.size(), v[i].nwr);
    for (int j = 0; j < v[i].nwr && j < wq_a.size(); j++) begin
      chk($sformatf("%s_ad%0d", nm, j), wq_a[j], v[i].wa[j]);
      chk($sformatf("%s_din%0d", nm, j), wq_d[j], v[i].wd[j]);
      chk($sformatf("%s_wre%0d", nm, j), wq_w[j], 1);
    end
    chk({nm, "_done"}, n_done, (v[i].tx == 8'h06) ? 1 : 0);
    chk({nm, "_err"}, err, v[i].err);
    chk({nm, "_hold"}, cpu_hold, 0);
    if (v[i].gap == 0 && wq_c.size() == v[i].nwr)
      chk({nm, "_b2b_span"}, wq_c[v[i].nwr-1] - wq_c[0], v[i].nwr - 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_tx_valid"}, tx_valid, 0);
    chk({nm, "_tx_data"}, tx_data, 0);
    chk({nm, "_ram_ce"}, ram_ce, 0);
    chk({nm, "_ram_wre"}, ram_wre, 0);
    chk({nm, "_ram_ad"}, ram_ad, 0);
    chk({nm, "_ram_din"}, ram_din, 0);
    chk({nm, "_hold"}, cpu_hold, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  initial begin
    int k, viol;
    v[0] = '{96'hA5001000031122339A000000, 9, 1, 8'h06, 3,
             {11'h010, 11'h011, 11'h012, 11'h0, 11'h0}, 40'h1122330000, 1'b0};
    v[1] = '{96'hA50010000311223300000000, 9, 2, 8'h15, 3,
             {11'h010, 11'h011, 11'h012, 11'h0, 11'h0}, 40'h1122330000, 1'b1};
    v[2] = '{96'hA507FF0002AA550100000000, 8, 1, 8'h06, 2,
             {11'h7FF, 11'h000, 11'h0, 11'h0, 11'h0}, 40'hAA55000000, 1'b0};
    v[3] = '{96'hA50000000000000000000000, 5, 1, 8'h15, 0,
             {11'h0, 11'h0, 11'h0, 11'h0, 11'h0}, 40'h0, 1'b1};
    v[4] = '{96'hA50000080100000000000000, 5, 1, 8'h15, 0,
             {11'h0, 11'h0, 11'h0, 11'h0, 11'h0}, 40'h0, 1'b1};
    v[5] = '{96'h3C5AA501000001FF01000000, 9, 1, 8'h06, 1,
             {11'h100, 11'h0, 11'h0, 11'h0, 11'h0}, 40'hFF00000000, 1'b0};
    v[6] = '{96'hA5F80500017E820000000000, 7, 1, 8'h06, 1,
             {11'h005, 11'h0, 11'h0, 11'h0, 11'h0}, 40'h7E00000000, 1'b0};
    v[7] = '{96'hA5020000050102030405F100, 11, 0, 8'h06, 5,
             {11'h200, 11'h201, 11'h202, 11'h203, 11'h204}, 40'h0102030405, 1'b0};

    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    n_done   = 0;
    #1;
    chk_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // inter-byte timeout after SYNC + ADDR_H
    clr_mon();
    send(8'hA5, 0);
    send(8'h00, 0);
    for (k = 0; k < 200; k++) begin
      if (tx_valid) break;
      @(posedge clk); #1;
    end
    chk("tmo_early", (k >= 95) ? 1 : 0, 1);
    chk("tmo_late", (k <= 105) ? 1 : 0, 1);
    wait_resp("tmo");
    if (rsp_q.size() > 0) chk("tmo_tx", rsp_q[0], 8'h15);
    chk("tmo_nwr", wq_a.size(), 0);
    chk("tmo_err", err, 1);
    chk("tmo_done", n_done, 0);
    chk("tmo_hold", cpu_hold, 0);

    // TX stall in RESP with stray rx bytes
    clr_mon();
    tx_ready = 1'b0;
    send(8'hA5, 1); send(8'h03, 1); send(8'h00, 1); send(8'h00, 1);
    send(8'h02, 1); send(8'h10, 1); send(8'h20, 1); send(8'hD0, 1);
    for (k = 0; k < 60; k++) begin
      if (tx_valid) break;
      @(posedge clk); #1;
    end
    chk("stall_tx_valid", tx_valid, 1);
    chk("stall_nwr", wq_a.size(), 2);
    if (wq_a.size() == 2) begin
      chk("stall_ad0", wq_a[0], 11'h300);
      chk("stall_ad1", wq_a[1], 11'h301);
    end
    wq_a.delete(); wq_d.delete(); wq_w.delete(); wq_c.delete();
    viol = 0;
    for (int j = 0; j < 20; j++) begin
      rx_valid = (j == 3 || j == 8 || j == 13);
      rx_data  = (j == 3) ? 8'hA5 : (j == 8) ? 8'h00 : 8'h7F;
      if (!tx_valid || tx_data !== 8'h06 || !cpu_hold) viol++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    chk("stall_stable", viol, 0);
    chk("stall_no_wr", wq_a.size(), 0);
    chk("stall_no_hs", rsp_q.size(), 0);
    tx_ready = 1'b1;
    wait_resp("stall");
    chk("stall_nresp", rsp_q.size(), 1);
    if (rsp_q.size() > 0) chk("stall_tx", rsp_q[0], 8'h06);
    chk("stall_done", n_done, 1);
    chk("stall_hold", cpu_hold, 0);
    run_vec(0);

    // reset in the middle of DATA
    clr_mon();
    send(8'hA5, 1); send(8'h04, 1); send(8'h00, 1); send(8'h00, 1);
    send(8'h04, 1); send(8'h11, 1); send(8'h22, 1);
    chk("rst_mid_hold_before", cpu_hold, 1);
    #2 resetn = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_nresp", rsp_q.size(), 0);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
